mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer_pkg.sv | 34 +++
 rtl/alu.sv | 48 ++++
 rtl/mult_sequencer.sv | 104 ++++++++++
 tb/tb_mult_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared constants for the Booth multiply sequencer and the processor top level.
//   - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - default iteration count (operand width)
//   - ALU opcodes used by the sequencer
//   - packed result record registered at the end of an operation
package mult_sequencer_pkg;

  localparam int ITER_DEFAULT = 32;
  localparam int DATA_W       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  localparam logic [4:0] ALU_OP_ADD = 5'd0;
  localparam logic [4:0] ALU_OP_SUB = 5'd1;
  localparam logic [4:0] ALU_OP_AND = 5'd2;
  localparam logic [4:0] ALU_OP_OR  = 5'd3;
  localparam logic [4:0] ALU_OP_SLL = 5'd4;
  localparam logic [4:0] ALU_OP_SRA = 5'd5;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              exception;
  } mult_res_t;

  // Radix-2 Booth pair {P[1],P[0]}: 01 adds M, 10 subtracts M, others hold.
  function automatic logic booth_is_arith(input logic [1:0] pair);
    return pair[1] ^ pair[0];
  endfunction

endpackage

// File: rtl/alu.sv
// Processor ALU; the multiply sequencer uses it as its only adder/subtractor.
// Ports:
//   data_operandA/B  : 32-bit operands
//   ctrl_ALUopcode   : 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra
//   ctrl_shiftamt    : shift distance for sll/sra
//   data_result      : 32-bit result
//   isNotEqual       : A != B
//   isLessThan       : signed A < B (valid when opcode is sub)
//   overflow         : signed overflow of the add/sub
module alu
  import mult_sequencer_pkg::*;
(
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_ALUopcode,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_result,
  output logic        isNotEqual,
  output logic        isLessThan,
  output logic        overflow
);

  logic        sub;
  logic [31:0] b_eff;
  logic [32:0] sum;

  // One shared adder: subtraction is A + ~B + 1.
  assign sub   = (ctrl_ALUopcode == ALU_OP_SUB);
  assign b_eff = sub ? ~data_operandB : data_operandB;
  assign sum   = {1'b0, data_operandA} + {1'b0, b_eff} + {32'd0, sub};

  assign overflow   = (data_operandA[31] == b_eff[31]) && (sum[31] != data_operandA[31]);
  assign isLessThan = sum[31] ^ overflow;
  assign isNotEqual = |(data_operandA ^ data_operandB);

  always_comb begin
    data_result = sum[31:0];
    case (ctrl_ALUopcode)
      ALU_OP_ADD, ALU_OP_SUB: data_result = sum[31:0];
      ALU_OP_AND:             data_result = data_operandA & data_operandB;
      ALU_OP_OR:              data_result = data_operandA | data_operandB;
      ALU_OP_SLL:             data_result = data_operandA << ctrl_shiftamt;
      ALU_OP_SRA:             data_result = $signed(data_operandA) >>> ctrl_shiftamt;
      default:                data_result = sum[31:0];
    endcase
  end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle radix-2 Booth multiplier, one iteration per clock.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   ctrl_MULT        : start request (accepted in IDLE or DONE)
//   data_operandA/B  : signed multiplicand / multiplier, captured on start
//   data_result      : low 32 bits of the signed product (registered)
//   data_exception   : product does not fit in 32 bits (registered)
//   data_resultRDY   : one-cycle pulse while the result is fresh
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam int CNT_W = $clog2(ITER + 1);

  mult_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [64:0]      p_q, p_d;
  logic [31:0]      m_q;
  mult_res_t        res_q, res_d;
  logic             rdy_q;

  logic [31:0] u, u_new, alu_res;
  logic [4:0]  alu_op;
  logic        arith, alu_ovf, msb;
  logic        alu_unused_ne, alu_unused_lt;

  assign u      = p_q[64:33];
  assign arith  = booth_is_arith(p_q[1:0]);
  assign alu_op = (p_q[1:0] == 2'b10) ? ALU_OP_SUB : ALU_OP_ADD;

  alu u_alu (
    .data_operandA  (u),
    .data_operandB  (m_q),
    .ctrl_ALUopcode (alu_op),
    .ctrl_shiftamt  (5'd0),
    .data_result    (alu_res),
    .isNotEqual     (alu_unused_ne),
    .isLessThan     (alu_unused_lt),
    .overflow       (alu_ovf)
  );

  always_comb begin
    u_new = arith ? alu_res : u;
    // The true U+/-M needs 33 bits; the sign bit shifted in is the 33rd bit,
    // recovered from the wrapped 32-bit result by flipping on overflow.
    msb   = arith ? (u_new[31] ^ alu_ovf) : u[31];
    p_d   = {msb, u_new, p_q[32:1]};
    res_d.result    = p_d[32:1];
    res_d.exception = (p_d[64:33] != {32{p_d[32]}});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (ctrl_MULT) begin
            m_q     <= data_operandA;
            p_q     <= {32'd0, data_operandB, 1'b0};
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // Last iteration: register the finished product as DONE is entered
          // so result and RDY are valid together for the DONE cycle.
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_q <= DONE;
            res_q   <= res_d;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_result    = res_q.result;
  assign data_exception = res_q.exception;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

  localparam int ITER  = 32;
  localparam int TMOUT = ITER + 8;

  logic        clock, reset, ctrl_MULT;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic        data_exception, data_resultRDY;

  int n_chk  = 0;
  int n_pass = 0;

  mult_sequencer #(.ITER(ITER)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: plain 64-bit signed product.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [31:0] lo;
    p  = longint'($signed(a)) * longint'($signed(b));
    lo = p[31:0];
    return {lo, (p != longint'($signed(lo)))};
  endfunction

  // Inputs are changed #1 after a posedge; they are sampled at the next one.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    step();
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input int n0, output int n);
    n = n0;
    while (n < TMOUT) begin
      step();
      n++;
      if (data_resultRDY) break;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b, input int n);
    logic [32:0] e;
    e = model(a, b);
    chk({tag, "_lat"}, 64'(n), 64'(ITER));
    chk({tag, "_res"}, 64'(data_result), 64'(e[32:1]));
    chk({tag, "_exc"}, 64'(data_exception), 64'(e[0]));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [32:0] e;
    start_op(a, b);
    wait_rdy(0, n);
    check_op(tag, a, b, n);
    e = model(a, b);
    step();
    chk({tag, "_pulse"}, 64'(data_resultRDY), 64'd0);
    chk({tag, "_hold"},  64'(data_result),    64'(e[32:1]));
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] a, b, a2, b2;
    logic [31:0] corners [8];
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                32'h7FFFFFFF, 32'h00010000, 32'hFFFF0000, 32'h2};

    reset = 1'b1; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
    repeat (3) step();
    chk("rst_res", 64'(data_result),    64'd0);
    chk("rst_exc", 64'(data_exception), 64'd0);
    chk("rst_rdy", 64'(data_resultRDY), 64'd0);
    reset = 1'b0;
    step();

    run_op("3x5",      32'd3,          32'd5);
    run_op("m7x6",     32'hFFFFFFF9,   32'd6);
    run_op("minxm1",   32'h80000000,   32'hFFFFFFFF);
    run_op("minx1",    32'h80000000,   32'd1);
    run_op("maxx2",    32'h7FFFFFFF,   32'd2);

    // Start request during RUN must be ignored.
    start_op(32'd4, 32'd4);
    repeat (8) step();
    ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
    step();
    ctrl_MULT = 1'b0;
    wait_rdy(9, n);
    check_op("midstart", 32'd4, 32'd4, n);
    step();

    // Reset mid-operation aborts with no RDY and cleared outputs.
    start_op(32'd4, 32'd4);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_res", 64'(data_result),    64'd0);
    chk("abort_exc", 64'(data_exception), 64'd0);
    seen = 1'b0;
    repeat (TMOUT) begin
      step();
      if (data_resultRDY) seen = 1'b1;
    end
    chk("abort_nordy", 64'(seen), 64'd0);
    run_op("2x3", 32'd2, 32'd3);

    // Reset wins over a simultaneous start.
    ctrl_MULT = 1'b1; reset = 1'b1; data_operandA = 32'd5; data_operandB = 32'd5;
    step();
    ctrl_MULT = 1'b0; reset = 1'b0;
    wait_rdy(0, n);
    chk("rst_prio", 64'(n), 64'(TMOUT));

    // Back-to-back: new start accepted in the DONE cycle.
    a = 32'hFFFFFF00; b = 32'd77; a2 = 32'd12345; b2 = 32'hFFFFFFFE;
    start_op(a, b);
    wait_rdy(0, n);
    check_op("b2b_1", a, b, n);
    start_op(a2, b2);
    chk("b2b_rdylow", 64'(data_resultRDY), 64'd0);
    wait_rdy(0, n);
    check_op("b2b_2", a2, b2, n);
    step();

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = corners[$urandom_range(0, 7)]; b = corners[$urandom_range(0, 7)]; end
        default: begin a = 32'($signed(16'($urandom))); b = $urandom; end
      endcase
      run_op($sformatf("rnd%0d", i), a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
